// File: rtl/pdp8_tape_loader_pkg.sv
// Shared types and constants for the PDP-8 paper-tape bootstrap loader.
package pdp8_tape_loader_pkg;

    typedef logic [11:0] word;

    typedef enum logic [2:0] {
        IDLE,
        GET_HI,
        GET_LO,
        SETUP,
        PULSE,
        RELEASE,
        RUN_WAIT,
        DONE
    } loader_state_t;

    localparam logic [7:0] TAPE_LEADER     = 8'o200;
    localparam int         TAPE_ORIGIN_BIT = 6;

    // Any frame with the top channel punched is leader/trailer, not data.
    function automatic logic is_leader(input logic [7:0] frame);
        return (frame & TAPE_LEADER) != 8'd0;
    endfunction

endpackage

// File: rtl/pdp8_tape_loader_assembler.sv
// Pairs BIN-format tape frames into 12-bit words, filters leader/trailer
// frames and exposes the origin flag carried in the high frame.
module tape_frame_assembler
    import pdp8_tape_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_accept,
    input  logic        want_lo,
    input  logic [7:0]  frame,
    output logic        hi_strobe,
    output logic        lo_strobe,
    output logic [11:0] pair_word,
    output logic        origin
);

    logic [6:0] hi_reg;
    logic       data_frame;

    assign data_frame = frame_accept && !is_leader(frame);
    assign hi_strobe  = data_frame && !want_lo;
    assign lo_strobe  = data_frame && want_lo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_reg <= '0;
        end else if (hi_strobe) begin
            hi_reg <= frame[6:0];
        end
    end

    // The low frame is combined straight off the bus so the word is ready on
    // the same edge that accepts it.
    assign pair_word = {hi_reg[5:0], frame[5:0]};
    assign origin    = hi_reg[TAPE_ORIGIN_BIT];

endmodule

// File: rtl/pdp8_tape_loader.sv
// Replays a BIN paper tape into the front panel (switches, Load PC, Deposit)
// and then starts the CPU from START_PC.
module pdp8_tape_loader
    import pdp8_tape_loader_pkg::*;
#(
    parameter int          SETUP_CYC = 10,
    parameter int          PULSE_CYC = 10,
    parameter logic [11:0] START_PC  = 12'o200
)
(
    input  logic        clk,
    input  logic        btnCpuReset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    input  logic        tape_end,
    output logic [11:0] panel_sw,
    output logic        load_pc,
    output logic        deposit,
    output logic        run,
    output logic        busy,
    output logic        fmt_err,
    output logic [11:0] word_count
);

    localparam int CNT_MAX = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);

    loader_state_t    state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    word              panel_sw_reg;
    word              word_count_reg;
    logic             load_pc_reg;
    logic             deposit_reg;
    logic             run_reg;
    logic             busy_reg;
    logic             fmt_err_reg;
    logic             final_reg;

    logic             frame_accept;
    logic             hi_strobe;
    logic             lo_strobe;
    word              pair_word;
    logic             asm_origin;
    logic             end_in_hi;
    logic             end_in_lo;
    logic             sel_load;
    logic             entering_pulse;

    assign byte_ready   = (state_reg == GET_HI) || (state_reg == GET_LO);
    assign frame_accept = byte_valid && byte_ready;

    tape_frame_assembler u_assembler (
        .clk          (clk),
        .rst_n        (btnCpuReset),
        .frame_accept (frame_accept),
        .want_lo      (state_reg == GET_LO),
        .frame        (byte_in),
        .hi_strobe    (hi_strobe),
        .lo_strobe    (lo_strobe),
        .pair_word    (pair_word),
        .origin       (asm_origin)
    );

    // A valid frame always takes priority over the end-of-tape indication.
    assign end_in_hi = (state_reg == GET_HI) && !byte_valid && tape_end;
    assign end_in_lo = (state_reg == GET_LO) && !byte_valid && tape_end;

    assign sel_load       = final_reg || asm_origin;
    assign entering_pulse = (state_reg == SETUP) && (state_next == PULSE);

    always_comb begin
        state_next = state_reg;
        cnt_next   = (cnt_reg != '0) ? cnt_reg - 1'b1 : cnt_reg;
        case (state_reg)
            IDLE: begin
                if (start) state_next = GET_HI;
            end
            GET_HI: begin
                if (hi_strobe) begin
                    state_next = GET_LO;
                end else if (end_in_hi) begin
                    state_next = SETUP;
                    cnt_next   = SETUP_LOAD;
                end
            end
            GET_LO: begin
                if (lo_strobe) begin
                    state_next = SETUP;
                    cnt_next   = SETUP_LOAD;
                end else if (end_in_lo) begin
                    state_next = DONE;
                end
            end
            SETUP: begin
                if (cnt_reg == '0) begin
                    state_next = PULSE;
                    cnt_next   = PULSE_LOAD;
                end
            end
            PULSE: begin
                if (cnt_reg == '0) begin
                    state_next = RELEASE;
                    cnt_next   = PULSE_LOAD;
                end
            end
            RELEASE: begin
                if (cnt_reg == '0) begin
                    if (final_reg) begin
                        state_next = RUN_WAIT;
                        cnt_next   = SETUP_LOAD;
                    end else begin
                        state_next = GET_HI;
                    end
                end
            end
            RUN_WAIT: begin
                if (cnt_reg == '0) state_next = DONE;
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            panel_sw_reg   <= '0;
            word_count_reg <= '0;
            load_pc_reg    <= 1'b0;
            deposit_reg    <= 1'b0;
            run_reg        <= 1'b0;
            busy_reg       <= 1'b0;
            fmt_err_reg    <= 1'b0;
            final_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;

            if (lo_strobe) begin
                panel_sw_reg <= pair_word;
            end else if (end_in_hi) begin
                panel_sw_reg <= START_PC;
                final_reg    <= 1'b1;
            end

            if (end_in_lo) fmt_err_reg <= 1'b1;

            // Buttons are registered off the next state so they track PULSE
            // exactly and drop with the async reset.
            load_pc_reg <= (state_next == PULSE) && sel_load;
            deposit_reg <= (state_next == PULSE) && !sel_load;

            if (entering_pulse && !sel_load) word_count_reg <= word_count_reg + 12'd1;

            run_reg  <= (state_next == DONE) && final_reg;
            busy_reg <= (state_next != IDLE) && (state_next != DONE);
        end
    end

    assign panel_sw   = panel_sw_reg;
    assign load_pc    = load_pc_reg;
    assign deposit    = deposit_reg;
    assign run        = run_reg;
    assign busy       = busy_reg;
    assign fmt_err    = fmt_err_reg;
    assign word_count = word_count_reg;

endmodule

// File: tb/tb_pdp8_tape_loader.sv
// Self-checking bench for pdp8_tape_loader: directed tape table, randomized
// tapes against a tape-level reference model, async reset and counter wrap.
module tb_pdp8_tape_loader;

    localparam int SETUP_CYC = 10;
    localparam int PULSE_CYC = 10;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        btnCpuReset, start, byte_valid, tape_end;
    logic [7:0]  byte_in;
    logic        byte_ready, load_pc, deposit, run, busy, fmt_err;
    logic [11:0] panel_sw, word_count;

    logic        rst_nf, start_f;
    logic        byte_ready_f, load_pc_f, deposit_f, run_f, busy_f, fmt_err_f;
    logic [11:0] panel_sw_f, word_count_f;

    pdp8_tape_loader #(.SETUP_CYC(SETUP_CYC), .PULSE_CYC(PULSE_CYC), .START_PC(12'o200)) dut (
        .clk(clk), .btnCpuReset(btnCpuReset), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .tape_end(tape_end),
        .panel_sw(panel_sw), .load_pc(load_pc), .deposit(deposit), .run(run),
        .busy(busy), .fmt_err(fmt_err), .word_count(word_count)
    );

    pdp8_tape_loader #(.SETUP_CYC(1), .PULSE_CYC(1), .START_PC(12'o200)) dut_fast (
        .clk(clk), .btnCpuReset(rst_nf), .start(start_f), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready_f), .tape_end(tape_end),
        .panel_sw(panel_sw_f), .load_pc(load_pc_f), .deposit(deposit_f), .run(run_f),
        .busy(busy_f), .fmt_err(fmt_err_f), .word_count(word_count_f)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        is_load;
        logic [11:0] sw;
    } ev_t;

    ev_t         got_q[$];
    ev_t         exp_q[$];
    logic [7:0]  tape_q[$];
    logic [11:0] top_mem [4096];
    int          top_pc = 0;
    logic [11:0] exp_mem [int];
    bit          exp_run, exp_err;
    int          exp_wc;
    bit          mon_en = 1'b0;
    int          fast_deps = 0, fast_loads = 0;

    // Observer standing in for Top: records button presses, checks panel timing.
    initial begin : monitor
        logic pl, pd, bad;
        logic [11:0] psw;
        int stable, hi_cnt, low_cnt;
        bit armed;
        pl = 0; pd = 0; psw = '0; stable = 0; hi_cnt = 0; low_cnt = 0; armed = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                pl = 0; pd = 0; psw = panel_sw; stable = 0; hi_cnt = 0; low_cnt = 0; armed = 0;
            end else begin
                bad = (load_pc && deposit) || ((load_pc || deposit) && (byte_ready || !busy))
                      || (byte_ready && !busy);
                chk("cycle_invariant", 32'(bad), 32'd0);
                if (panel_sw != psw) begin
                    if (armed) chk("low_before_sw_change", 32'(low_cnt >= PULSE_CYC), 32'd1);
                    armed = 0;
                    stable = 0;
                end else begin
                    stable++;
                end
                if ((load_pc && !pl) || (deposit && !pd)) begin
                    chk("sw_setup_before_edge", 32'(stable >= SETUP_CYC), 32'd1);
                    got_q.push_back(ev_t'({load_pc, panel_sw}));
                    if (load_pc) begin
                        top_pc = int'(panel_sw);
                    end else begin
                        top_mem[top_pc] = panel_sw;
                        top_pc = (top_pc + 1) % 4096;
                    end
                    hi_cnt = 1;
                end else if (load_pc || deposit) begin
                    hi_cnt++;
                end
                if ((pl && !load_pc) || (pd && !deposit)) begin
                    chk("pulse_width", 32'(hi_cnt), 32'(PULSE_CYC));
                    armed = 1;
                    low_cnt = 1;
                end else if (armed) begin
                    low_cnt++;
                end
                pl = load_pc; pd = deposit; psw = panel_sw;
            end
        end
    end

    initial begin : fast_monitor
        logic pl, pd;
        pl = 0; pd = 0;
        forever begin
            @(negedge clk);
            if (deposit_f && !pd) fast_deps++;
            if (load_pc_f && !pl) fast_loads++;
            pl = load_pc_f; pd = deposit_f;
        end
    end

    // Reference model: works on the whole tape as a list of frames.
    task automatic build_expect();
        int data[$];
        int pc, wc, hi, lo, w;
        exp_q.delete();
        exp_mem.delete();
        pc = -1;
        wc = 0;
        foreach (tape_q[k]) if (tape_q[k] < 8'd128) data.push_back(int'(tape_q[k]));
        for (int p = 0; p < data.size() / 2; p++) begin
            hi = data[2*p];
            lo = data[2*p+1];
            w  = (hi % 64) * 64 + (lo % 64);
            if (hi >= 64) begin
                exp_q.push_back(ev_t'({1'b1, 12'(w)}));
                pc = w;
            end else begin
                exp_q.push_back(ev_t'({1'b0, 12'(w)}));
                wc++;
                if (pc >= 0) begin
                    exp_mem[pc] = 12'(w);
                    pc = (pc + 1) % 4096;
                end
            end
        end
        exp_err = (data.size() % 2) != 0;
        exp_run = !exp_err;
        if (exp_run) exp_q.push_back(ev_t'({1'b1, 12'o200}));
        exp_wc = wc % 4096;
    endtask

    task automatic do_reset();
        mon_en = 0;
        btnCpuReset = 0;
        start = 0;
        byte_valid = 0;
        tape_end = 0;
        repeat (3) @(negedge clk);
        btnCpuReset = 1;
        got_q.delete();
        @(negedge clk);
        mon_en = 1;
    endtask

    task automatic pulse_start(input bit fast);
        @(negedge clk);
        if (fast) start_f = 1; else start = 1;
        @(negedge clk);
        start_f = 0;
        start = 0;
    endtask

    task automatic feed(input bit rnd, input bit te_early, input bit fast);
        int i = 0;
        int budget = 0;
        while (i < tape_q.size() && budget < 60000) begin
            @(negedge clk);
            budget++;
            if (rnd && $urandom_range(0, 2) == 0) begin
                byte_valid = 0;
            end else begin
                byte_valid = 1;
                byte_in = tape_q[i];
                if (te_early && i == tape_q.size() - 1) tape_end = 1;
                if (fast ? byte_ready_f : byte_ready) i++;
            end
        end
        chk("feed_within_budget", 32'(budget < 60000), 32'd1);
        @(negedge clk);
        byte_valid = 0;
    endtask

    task automatic wait_idle(input int budget, input bit fast);
        int n = 0;
        tape_end = 1;
        do begin
            @(negedge clk);
            n++;
        end while ((fast ? busy_f : busy) && n < budget);
        chk("done_within_budget", 32'(n < budget), 32'd1);
        tape_end = 0;
    endtask

    task automatic run_and_check(input string name, input bit rnd, input bit te_early);
        pulse_start(0);
        feed(rnd, te_early, 0);
        wait_idle(2000, 0);
        build_expect();
        chk({name, "_events"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_event%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
        chk({name, "_run"}, 32'(run), 32'(exp_run));
        chk({name, "_fmt_err"}, 32'(fmt_err), 32'(exp_err));
        chk({name, "_word_count"}, 32'(word_count), 32'(exp_wc));
        chk({name, "_busy"}, 32'(busy), 32'd0);
        foreach (exp_mem[a]) chk($sformatf("%s_mem%0o", name, a), 32'(top_mem[a]), 32'(exp_mem[a]));
        $display("%s: %0d frames, %0d pulses, run=%0d fmt_err=%0d word_count=%0d",
                 name, tape_q.size(), got_q.size(), run, fmt_err, word_count);
    endtask

    typedef struct packed {
        logic [7:0][7:0] fr;
        logic [3:0]      n;
        logic            exp_run;
        logic            exp_err;
        logic [11:0]     exp_wc;
        logic [3:0]      exp_loads;
        logic [3:0]      exp_deps;
    } vec_t;

    initial begin : main
        vec_t vecs [6];
        int loads, deps, nw;
        logic [7:0] b;

        vecs[0] = '{fr: {8'o200, 8'o200, 8'o102, 8'o000, 8'o017, 8'o077, 8'o200, 8'o000},
                    n: 4'd7, exp_run: 1'b1, exp_err: 1'b0, exp_wc: 12'd1, exp_loads: 4'd2, exp_deps: 4'd1};
        vecs[1] = '{fr: {8'o102, 8'o000, 8'o017, 8'o000, 8'o000, 8'o000, 8'o000, 8'o000},
                    n: 4'd3, exp_run: 1'b0, exp_err: 1'b1, exp_wc: 12'd0, exp_loads: 4'd1, exp_deps: 4'd0};
        vecs[2] = '{fr: {8'o200, 8'o200, 8'o000, 8'o000, 8'o000, 8'o000, 8'o000, 8'o000},
                    n: 4'd2, exp_run: 1'b1, exp_err: 1'b0, exp_wc: 12'd0, exp_loads: 4'd1, exp_deps: 4'd0};
        vecs[3] = '{fr: {8'o001, 8'o002, 8'o200, 8'o077, 8'o077, 8'o000, 8'o000, 8'o000},
                    n: 4'd5, exp_run: 1'b1, exp_err: 1'b0, exp_wc: 12'd2, exp_loads: 4'd1, exp_deps: 4'd2};
        vecs[4] = '{fr: {8'o045, 8'o200, 8'o200, 8'o012, 8'o200, 8'o000, 8'o000, 8'o000},
                    n: 4'd5, exp_run: 1'b1, exp_err: 1'b0, exp_wc: 12'd1, exp_loads: 4'd1, exp_deps: 4'd1};
        vecs[5] = '{fr: {8'o000, 8'o000, 8'o000, 8'o000, 8'o000, 8'o000, 8'o000, 8'o000},
                    n: 4'd0, exp_run: 1'b1, exp_err: 1'b0, exp_wc: 12'd0, exp_loads: 4'd1, exp_deps: 4'd0};

        btnCpuReset = 0; rst_nf = 0; start = 0; start_f = 0;
        byte_valid = 0; tape_end = 0; byte_in = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_panel_sw", 32'(panel_sw), 32'd0);
        chk("reset_buttons", 32'({load_pc, deposit, run}), 32'd0);
        chk("reset_busy_ready", 32'({busy, byte_ready}), 32'd0);
        chk("reset_fmt_err", 32'(fmt_err), 32'd0);
        chk("reset_word_count", 32'(word_count), 32'd0);

        // Directed tapes
        for (int r = 0; r < 6; r++) begin
            tape_q.delete();
            for (int i = 0; i < int'(vecs[r].n); i++) tape_q.push_back(vecs[r].fr[7-i]);
            do_reset();
            run_and_check($sformatf("vec%0d", r), 0, (r % 2) == 1);
            loads = 0; deps = 0;
            foreach (got_q[i]) if (got_q[i].is_load) loads++; else deps++;
            chk($sformatf("vec%0d_tbl_loads", r), 32'(loads), 32'(vecs[r].exp_loads));
            chk($sformatf("vec%0d_tbl_deps", r), 32'(deps), 32'(vecs[r].exp_deps));
            chk($sformatf("vec%0d_tbl_run", r), 32'(run), 32'(vecs[r].exp_run));
            chk($sformatf("vec%0d_tbl_err", r), 32'(fmt_err), 32'(vecs[r].exp_err));
            chk($sformatf("vec%0d_tbl_wc", r), 32'(word_count), 32'(vecs[r].exp_wc));
            if (vecs[r].exp_run && got_q.size() > 0)
                chk($sformatf("vec%0d_tbl_final_pc", r), 32'(got_q[got_q.size()-1].sw), 32'o200);
        end

        // Randomized tapes with irregular byte_valid
        for (int r = 0; r < 6; r++) begin
            tape_q.delete();
            nw = 4;
            tape_q.push_back(8'o200);
            tape_q.push_back(8'(64 + $urandom_range(0, 63)));
            tape_q.push_back(8'($urandom_range(0, 127)));
            for (int w = 0; w < nw + 1; w++) begin
                if ($urandom_range(0, 3) == 0) tape_q.push_back(8'(128 + $urandom_range(0, 127)));
                b = (w == 2 && r % 2 == 0) ? 8'(64 + $urandom_range(0, 63)) : 8'($urandom_range(0, 63));
                if (w < nw || b >= 8'd64) begin
                    tape_q.push_back(b);
                    tape_q.push_back(8'($urandom_range(0, 127)));
                end
            end
            if (r == 5) void'(tape_q.pop_back());
            tape_q.push_back(8'o200);
            do_reset();
            run_and_check($sformatf("rand%0d", r), 1, 0);
        end

        // Async reset in the middle of a deposit pulse, then a clean reload
        do_reset();
        tape_q = '{8'o102, 8'o000, 8'o017, 8'o077};
        pulse_start(0);
        feed(0, 0, 0);
        nw = 0;
        while (!deposit && nw < 200) begin
            @(negedge clk);
            nw++;
        end
        chk("reset_test_deposit_seen", 32'(deposit), 32'd1);
        mon_en = 0;
        @(negedge clk);
        #2 btnCpuReset = 0;
        #1;
        chk("async_reset_deposit", 32'(deposit), 32'd0);
        chk("async_reset_busy", 32'(busy), 32'd0);
        chk("async_reset_run_ready", 32'({run, byte_ready}), 32'd0);
        chk("async_reset_word_count", 32'(word_count), 32'd0);
        $display("async reset during deposit: deposit=%0d busy=%0d word_count=%0d", deposit, busy, word_count);
        do_reset();
        tape_q.delete();
        for (int i = 0; i < int'(vecs[0].n); i++) tape_q.push_back(vecs[0].fr[7-i]);
        run_and_check("restart", 0, 0);
        chk("restart_word_count", 32'(word_count), 32'd1);

        // 4097 deposits on the fast instance: counter wraps to 1
        tape_q.delete();
        tape_q.push_back(8'o100);
        tape_q.push_back(8'o000);
        for (int w = 0; w < 4097; w++) begin
            tape_q.push_back(8'($urandom_range(0, 63)));
            tape_q.push_back(8'($urandom_range(0, 63)));
        end
        repeat (2) @(negedge clk);
        rst_nf = 1;
        fast_deps = 0;
        fast_loads = 0;
        pulse_start(1);
        feed(0, 0, 1);
        wait_idle(200, 1);
        chk("wrap_word_count", 32'(word_count_f), 32'd1);
        chk("wrap_deposits", 32'(fast_deps), 32'd4097);
        chk("wrap_loads", 32'(fast_loads), 32'd2);
        chk("wrap_run", 32'({run_f, fmt_err_f}), 32'b10);
        $display("wrap: deposits=%0d word_count=%0d run=%0d", fast_deps, word_count_f, run_f);
        pulse_start(1);
        repeat (5) @(negedge clk);
        chk("done_start_busy", 32'(busy_f), 32'd0);
        chk("done_start_ready", 32'(byte_ready_f), 32'd0);
        chk("done_start_run", 32'(run_f), 32'd1);
        chk("done_start_word_count", 32'(word_count_f), 32'd1);
        $display("start in DONE: busy=%0d run=%0d word_count=%0d", busy_f, run_f, word_count_f);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d errors so far, required completion", errors);
        $fatal(1, "simulation timeout");
    end

endmodule
